// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock-enable, X/Y raster counters, polarity-configurable
// sync, visible-area blank and a PIPE-deep sync/blank delay line advanced on pixel steps.
module vga_timing_gen #(
  parameter int   CW      = 10,
  parameter int   H_VA    = 640,
  parameter int   H_FP    = 16,
  parameter int   H_SP    = 96,
  parameter int   H_BP    = 48,
  parameter int   V_VA    = 480,
  parameter int   V_FP    = 10,
  parameter int   V_SP    = 2,
  parameter int   V_BP    = 33,
  parameter int   CLK_DIV = 2,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   PIPE    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic [CW-1:0] Q_X,
  output logic [CW-1:0] Q_Y,
  output logic          active,
  output logic          Hs,
  output logic          Vs,
  output logic          VGA_Blank,
  output logic          VGA_Sync_N,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOT = H_VA + H_FP + H_SP + H_BP;
  localparam int V_TOT = V_VA + V_FP + V_SP + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOT - 1);

  localparam logic [31:0] HS_BEG = 32'(H_VA + H_FP);
  localparam logic [31:0] HS_END = 32'(H_VA + H_FP + H_SP);
  localparam logic [31:0] VS_BEG = 32'(V_VA + V_FP);
  localparam logic [31:0] VS_END = 32'(V_VA + V_FP + V_SP);
  localparam logic [31:0] X_VIS  = 32'(H_VA);
  localparam logic [31:0] Y_VIS  = 32'(V_VA);

  if (((H_TOT - 1) >> CW) != 0) begin : g_chk_h
    $error("vga_timing_gen: H_TOT-1 does not fit in CW bits");
  end
  if (((V_TOT - 1) >> CW) != 0) begin : g_chk_v
    $error("vga_timing_gen: V_TOT-1 does not fit in CW bits");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (PIPE < 0 || PIPE > 4) begin : g_chk_pipe
    $error("vga_timing_gen: PIPE must be in 0..4");
  end

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [15:0]   r_frame_cnt;

  logic          w_pix_ce;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_line_start;
  logic          w_frame_start;
  logic [31:0]   w_x32;
  logic [31:0]   w_y32;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic          w_active;
  logic          w_hs_d;
  logic          w_vs_d;
  logic          w_act_d;

  // Gating with rst keeps every strobe low while reset is held, even when CLK_DIV=1.
  assign w_pix_ce      = en & rst & (r_div == DIV_LAST);
  assign w_x_last      = (r_x == X_LAST);
  assign w_y_last      = (r_y == Y_LAST);
  assign w_line_start  = w_pix_ce & w_x_last;
  assign w_frame_start = w_line_start & w_y_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (en) begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
    end else if (w_pix_ce) begin
      if (w_x_last) begin
        r_x <= '0;
        if (w_y_last) begin
          r_y         <= '0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_y <= r_y + 1'b1;
        end
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_x32    = 32'(r_x);
  assign w_y32    = 32'(r_y);
  assign w_hs_raw = (w_x32 >= HS_BEG) && (w_x32 < HS_END);
  assign w_vs_raw = (w_y32 >= VS_BEG) && (w_y32 < VS_END);
  assign w_active = (w_x32 < X_VIS) && (w_y32 < Y_VIS);

  if (PIPE == 0) begin : g_nopipe
    assign w_hs_d  = w_hs_raw;
    assign w_vs_d  = w_vs_raw;
    assign w_act_d = w_active;
  end else begin : g_pipe
    // Stages hold raw (pre-polarity) levels so reset value 0 means "deasserted, not visible".
    logic [2:0] r_pipe [PIPE];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < PIPE; i++) begin
          r_pipe[i] <= 3'b000;
        end
      end else if (w_pix_ce) begin
        r_pipe[0] <= {w_hs_raw, w_vs_raw, w_active};
        for (int i = 1; i < PIPE; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign {w_hs_d, w_vs_d, w_act_d} = r_pipe[PIPE-1];
  end

  assign pix_ce      = w_pix_ce;
  assign Q_X         = r_x;
  assign Q_Y         = r_y;
  assign active      = w_active;
  assign Hs          = w_hs_d ? HS_POL : ~HS_POL;
  assign Vs          = w_vs_d ? VS_POL : ~VS_POL;
  assign VGA_Blank   = w_act_d;
  assign VGA_Sync_N  = 1'b1;
  assign line_start  = w_line_start;
  assign frame_start = w_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing (a), a tiny 8x6 raster (b)
// and a PIPE=2 / HS_POL=1 variant (c), each with its own reset and enable.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic        rst_a, en_a, rst_b, en_b, rst_c, en_c;

  logic        a_pix_ce, a_active, a_hs, a_vs, a_blank, a_sync_n, a_ls, a_fs;
  logic [9:0]  a_x, a_y;
  logic [15:0] a_fc;

  logic        b_pix_ce, b_active, b_hs, b_vs, b_blank, b_sync_n, b_ls, b_fs;
  logic [3:0]  b_x, b_y;
  logic [15:0] b_fc;

  logic        c_pix_ce, c_active, c_hs, c_vs, c_blank, c_sync_n, c_ls, c_fs;
  logic [9:0]  c_x, c_y;
  logic [15:0] c_fc;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pix_ce(a_pix_ce), .Q_X(a_x), .Q_Y(a_y),
    .active(a_active), .Hs(a_hs), .Vs(a_vs), .VGA_Blank(a_blank), .VGA_Sync_N(a_sync_n),
    .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .CW(4), .H_VA(4), .H_FP(1), .H_SP(2), .H_BP(1),
    .V_VA(3), .V_FP(1), .V_SP(1), .V_BP(1), .CLK_DIV(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pix_ce(b_pix_ce), .Q_X(b_x), .Q_Y(b_y),
    .active(b_active), .Hs(b_hs), .Vs(b_vs), .VGA_Blank(b_blank), .VGA_Sync_N(b_sync_n),
    .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_timing_gen #(.PIPE(2), .HS_POL(1'b1)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .pix_ce(c_pix_ce), .Q_X(c_x), .Q_Y(c_y),
    .active(c_active), .Hs(c_hs), .Vs(c_vs), .VGA_Blank(c_blank), .VGA_Sync_N(c_sync_n),
    .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ax(input int v);
    int n;
    n = 0;
    while (a_x !== 10'(v) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) check("a_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cx(input int v);
    int n;
    n = 0;
    while (c_x !== 10'(v) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) check("c_wait_timeout", 32'd0, 32'd1);
  endtask

  int t1, t2, fs_seen;
  int hs_cnt, hs_min, hs_max, bl_cnt, bl_min, bl_max, vs_low;
  int hold_err;
  int ex, ey, seq_err, over_err, hs_err, vs_err, bl_err, ls_err, fs_err, fc_err;
  int fs_first, fs_cnt, fs_prev, fs_gap_err;

  initial begin
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b1;
    rst_c = 1'b0; en_c = 1'b1;
    repeat (3) step();

    // ---------------- dut_a: reset state ----------------
    check("a_rst_x",      32'(a_x),      32'd0);
    check("a_rst_y",      32'(a_y),      32'd0);
    check("a_rst_fc",     32'(a_fc),     32'd0);
    check("a_rst_pix_ce", 32'(a_pix_ce), 32'd0);
    check("a_rst_ls",     32'(a_ls),     32'd0);
    check("a_rst_fs",     32'(a_fs),     32'd0);
    check("a_rst_hs",     32'(a_hs),     32'd1);
    check("a_rst_vs",     32'(a_vs),     32'd1);
    check("a_rst_blank",  32'(a_blank),  32'd1);
    check("a_sync_n",     32'(a_sync_n), 32'd1);
    rst_a = 1'b1;

    // ---------------- dut_a: line_start spacing ----------------
    t1 = -1; t2 = -1; fs_seen = 0;
    for (int k = 0; k < 4000 && t2 < 0; k++) begin
      step();
      if (a_fs) fs_seen++;
      if (a_ls) begin
        if (t1 < 0) t1 = k;
        else        t2 = k;
      end
    end
    if (t2 < 0) begin
      check("a_ls_timeout", 32'd0, 32'd1);
    end else begin
      check("a_ls_first",  32'(t1),      32'd1598);
      check("a_ls_period", 32'(t2 - t1), 32'd1600);
    end
    check("a_no_fs_partial", 32'(fs_seen), 32'd0);

    // ---------------- dut_a: one full line (line 2) ----------------
    hs_cnt = 0; hs_min = 9999; hs_max = -1;
    bl_cnt = 0; bl_min = 9999; bl_max = -1; vs_low = 0;
    for (int j = 0; j < 1600; j++) begin
      step();
      if (j == 0) begin
        check("a_line_x0", 32'(a_x), 32'd0);
        check("a_line_y",  32'(a_y), 32'd2);
      end
      if (a_pix_ce) begin
        if (!a_hs) begin
          hs_cnt++;
          if (int'(a_x) < hs_min) hs_min = int'(a_x);
          if (int'(a_x) > hs_max) hs_max = int'(a_x);
        end
        if (a_blank) begin
          bl_cnt++;
          if (int'(a_x) < bl_min) bl_min = int'(a_x);
          if (int'(a_x) > bl_max) bl_max = int'(a_x);
        end
        if (!a_vs) vs_low++;
      end
    end
    check("a_hs_cnt",   32'(hs_cnt), 32'd96);
    check("a_hs_min",   32'(hs_min), 32'd656);
    check("a_hs_max",   32'(hs_max), 32'd751);
    check("a_bl_cnt",   32'(bl_cnt), 32'd640);
    check("a_bl_min",   32'(bl_min), 32'd0);
    check("a_bl_max",   32'(bl_max), 32'd639);
    check("a_vs_line2", 32'(vs_low), 32'd0);

    // ---------------- dut_a: enable hold at Q_X=100 ----------------
    wait_ax(100);
    en_a = 1'b0;
    hold_err = 0;
    repeat (37) begin
      step();
      if (a_x !== 10'd100 || a_y !== 10'd3 || a_pix_ce || a_ls || a_fs) hold_err++;
    end
    check("a_hold_err", 32'(hold_err), 32'd0);
    en_a = 1'b1;
    step();
    check("a_resume_x",  32'(a_x),      32'd100);
    check("a_resume_ce", 32'(a_pix_ce), 32'd1);
    step();
    check("a_resume_x1", 32'(a_x),      32'd101);

    // ---------------- dut_a: asynchronous reset at Q_X=300 ----------------
    wait_ax(300);
    check("a_pre_rst_y", 32'(a_y), 32'd3);
    #2;
    rst_a = 1'b0;
    #1;
    check("a_async_x",  32'(a_x),      32'd0);
    check("a_async_y",  32'(a_y),      32'd0);
    check("a_async_ce", 32'(a_pix_ce), 32'd0);
    repeat (3) step();
    rst_a = 1'b1;
    check("a_rel_x", 32'(a_x), 32'd0);
    check("a_rel_y", 32'(a_y), 32'd0);
    step();
    check("a_rel_ce", 32'(a_pix_ce), 32'd1);
    step();
    check("a_rel_x1", 32'(a_x), 32'd1);

    // ---------------- dut_b: tiny 8x6 raster, CLK_DIV=1 ----------------
    rst_b = 1'b1;
    seq_err = 0; over_err = 0; hs_err = 0; vs_err = 0; bl_err = 0;
    ls_err = 0; fs_err = 0; fc_err = 0;
    fs_first = -1; fs_cnt = 0; fs_prev = -1; fs_gap_err = 0;
    for (int k = 0; k < 120; k++) begin
      ex = k % 8;
      ey = (k / 8) % 6;
      if (32'(b_x) != 32'(ex) || 32'(b_y) != 32'(ey)) seq_err++;
      if (32'(b_x) >= 32'd8 || 32'(b_y) >= 32'd6) over_err++;
      if (b_hs !== ((ex >= 5 && ex < 7) ? 1'b0 : 1'b1)) hs_err++;
      if (b_vs !== ((ey == 4) ? 1'b0 : 1'b1)) vs_err++;
      if (b_blank !== ((ex < 4 && ey < 3) ? 1'b1 : 1'b0)) bl_err++;
      if (b_ls !== ((ex == 7) ? 1'b1 : 1'b0)) ls_err++;
      if (b_fs !== ((ex == 7 && ey == 5) ? 1'b1 : 1'b0)) fs_err++;
      if (32'(b_fc) != 32'(k / 48)) fc_err++;
      if (b_fs) begin
        if (fs_first < 0) fs_first = k;
        if (fs_prev >= 0 && k - fs_prev != 48) fs_gap_err++;
        fs_prev = k;
        fs_cnt++;
      end
      step();
    end
    check("b_seq_err",  32'(seq_err),    32'd0);
    check("b_overrun",  32'(over_err),   32'd0);
    check("b_hs_err",   32'(hs_err),     32'd0);
    check("b_vs_err",   32'(vs_err),     32'd0);
    check("b_bl_err",   32'(bl_err),     32'd0);
    check("b_ls_err",   32'(ls_err),     32'd0);
    check("b_fs_err",   32'(fs_err),     32'd0);
    check("b_fc_err",   32'(fc_err),     32'd0);
    check("b_fs_first", 32'(fs_first),   32'd47);
    check("b_fs_cnt",   32'(fs_cnt),     32'd2);
    check("b_fs_gap",   32'(fs_gap_err), 32'd0);
    check("b_fc_end",   32'(b_fc),       32'd2);

    // ---------------- dut_c: PIPE=2, HS_POL=1 ----------------
    check("c_rst_hs",    32'(c_hs),    32'd0);
    check("c_rst_vs",    32'(c_vs),    32'd1);
    check("c_rst_blank", 32'(c_blank), 32'd0);
    rst_c = 1'b1;
    check("c_fill_x0", 32'(c_blank), 32'd0);
    wait_cx(1);
    check("c_fill_x1", 32'(c_blank), 32'd0);
    wait_cx(2);
    check("c_fill_x2", 32'(c_blank), 32'd1);
    wait_cx(640);
    check("c_bl_x640", 32'(c_blank), 32'd1);
    wait_cx(641);
    check("c_bl_x641", 32'(c_blank), 32'd1);
    wait_cx(642);
    check("c_bl_x642", 32'(c_blank), 32'd0);
    wait_cx(656);
    check("c_hs_x656", 32'(c_hs), 32'd0);
    wait_cx(657);
    check("c_hs_x657", 32'(c_hs), 32'd0);
    wait_cx(658);
    check("c_hs_x658", 32'(c_hs), 32'd1);
    wait_cx(753);
    check("c_hs_x753", 32'(c_hs), 32'd1);
    wait_cx(754);
    check("c_hs_x754", 32'(c_hs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
